// File: rtl/core_trace_buf.sv
// core_trace_buf: packs retired-instruction records into a FWFT FIFO with sequence tagging and drop accounting
module core_trace_buf #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SEQ_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic                  clear,
  input  logic [31:0]           core_pc,
  input  logic [31:0]           core_inst,
  input  logic                  core_rf_we,
  input  logic [4:0]            core_rf_waddr,
  input  logic [31:0]           core_rf_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEQ_W-1:0]      out_seq,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_inst,
  output logic                  out_rd_we,
  output logic [4:0]            out_rd,
  output logic [31:0]           out_rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [SEQ_W-1:0]      drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int REC_W = SEQ_W + 32 + 32 + 1 + 5 + 32;
  logic [REC_W-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [SEQ_W-1:0]      r_seq, r_drop;
  logic                  r_ovf;
  logic                  w_attempt, w_full, w_pop, w_push, w_drop;
  logic [REC_W-1:0]      w_rec;
  assign w_attempt = trace_en & ~clear;
  // count never exceeds DEPTH, so its top bit alone marks the full state
  assign w_full    = r_count[DEPTH_LOG2];
  assign out_valid = r_count != '0;
  assign w_pop     = out_valid & out_ready & ~clear;
  assign w_push    = w_attempt & (~w_full | w_pop);
  assign w_drop    = w_attempt & w_full & ~w_pop;
  assign w_rec     = {r_seq, core_pc, core_inst, core_rf_we & (core_rf_waddr != 5'd0), core_rf_waddr, core_rf_wdata};
  assign {out_seq, out_pc, out_inst, out_rd_we, out_rd, out_rd_data} = out_valid ? r_mem[r_rptr] : '0;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;
  // record storage: written on accepted pushes only, never reset
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= w_rec;
  // pointers, occupancy, sequence and drop bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
      r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
      r_seq   <= w_attempt ? r_seq + 1'b1 : r_seq;
      r_drop  <= (w_drop && r_drop != '1) ? r_drop + 1'b1 : r_drop;
      r_ovf   <= r_ovf | w_drop;
    end
endmodule

// File: tb/tb_core_trace_buf.sv
// tb_core_trace_buf: directed self-checking bench for core_trace_buf
module tb_core_trace_buf;
  logic        clk = 1'b0, rst = 1'b1, trace_en = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [31:0] core_pc = '0, core_inst = '0, core_rf_wdata = '0;
  logic        core_rf_we = 1'b0;
  logic [4:0]  core_rf_waddr = '0;
  logic        out_valid, out_rd_we, overflow;
  logic [15:0] out_seq, drop_cnt;
  logic [31:0] out_pc, out_inst, out_rd_data;
  logic [4:0]  out_rd, count;
  int n_tests = 0, n_fail = 0;

  core_trace_buf #(.DEPTH_LOG2(4), .SEQ_W(16)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear),
    .core_pc(core_pc), .core_inst(core_inst), .core_rf_we(core_rf_we),
    .core_rf_waddr(core_rf_waddr), .core_rf_wdata(core_rf_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_pc(out_pc), .out_inst(out_inst), .out_rd_we(out_rd_we),
    .out_rd(out_rd), .out_rd_data(out_rd_data), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic fill(input int n);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      trace_en = 1'b1;
      core_pc = 32'(i * 4);
      step();
    end
    trace_en = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_tests++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_flags got ovf=%b drop=%0d exp 0/0", overflow, drop_cnt); end
    n_tests++; if (out_pc !== 32'd0 || out_seq !== 16'd0) begin n_fail++; $display("FAIL reset_payload got pc=%h seq=%0d exp 0/0", out_pc, out_seq); end
  endtask

  task automatic test_basic();
    core_inst = 32'h00500093; core_rf_we = 1'b1; core_rf_waddr = 5'd1; core_rf_wdata = 32'd5;
    fill(3);
    n_tests++; if (count !== 5'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_pc !== 32'(i * 4) || out_rd !== 5'd1 ||
          out_rd_data !== 32'd5 || out_rd_we !== 1'b1 || out_inst !== 32'h00500093) begin
        n_fail++;
        $display("FAIL basic_rec%0d got v=%b seq=%0d pc=%h rd=%0d we=%b data=%h exp seq=%0d pc=%h rd=1 we=1 data=5", i, out_valid, out_seq, out_pc, out_rd, out_rd_we, out_rd_data, i, i * 4);
      end
      step();
    end
    out_ready = 1'b0;
    n_tests++; if (count !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got count=%0d v=%b exp 0/0", count, out_valid); end
  endtask

  task automatic test_x0();
    core_rf_we = 1'b1; core_rf_waddr = 5'd0; core_rf_wdata = 32'h1234;
    trace_en = 1'b1; step(); trace_en = 1'b0;
    n_tests++;
    if (out_rd_we !== 1'b0 || out_rd !== 5'd0 || out_rd_data !== 32'h1234 || out_seq !== 16'd3) begin
      n_fail++;
      $display("FAIL x0_filter got we=%b rd=%0d data=%h seq=%0d exp 0/0/1234/3", out_rd_we, out_rd, out_rd_data, out_seq);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    fill(20);
    n_tests++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", count); end
    n_tests++; if (overflow !== 1'b1 || drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_flags got ovf=%b drop=%0d exp 1/4", overflow, drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (out_seq !== 16'(i) || out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL ovf_drain%0d got seq=%0d pc=%h exp %0d/%h", i, out_seq, out_pc, i, i * 4); end
      step();
    end
    out_ready = 1'b0;
    trace_en = 1'b1; step(); trace_en = 1'b0;
    n_tests++; if (out_seq !== 16'd20) begin n_fail++; $display("FAIL ovf_next_seq got %0d exp 20", out_seq); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    fill(16);
    trace_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_seq !== 16'(i) || count !== 5'd16) begin n_fail++; $display("FAIL b2b_cyc%0d got seq=%0d count=%0d exp %0d/16", i, out_seq, count, i); end
      step();
    end
    trace_en = 1'b0;
    n_tests++; if (count !== 5'd16 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_state got count=%0d drop=%0d ovf=%b exp 16/0/0", count, drop_cnt, overflow); end
    for (int i = 10; i < 26; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_seq !== 16'(i)) begin n_fail++; $display("FAIL b2b_drain got v=%b seq=%0d exp 1/%0d", out_valid, out_seq, i); end
      step();
    end
    out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got v=%b exp 0", out_valid); end
  endtask

  task automatic test_clear_reset();
    do_clear();
    fill(17);
    out_ready = 1'b1; repeat (11) step(); out_ready = 1'b0;
    n_tests++; if (count !== 5'd5 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_setup got count=%0d ovf=%b drop=%0d exp 5/1/1", count, overflow, drop_cnt); end
    clear = 1'b1; trace_en = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
    n_tests++; if (count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_state got count=%0d ovf=%b drop=%0d v=%b exp 0/0/0/0", count, overflow, drop_cnt, out_valid); end
    trace_en = 1'b1; step(); trace_en = 1'b0;
    n_tests++; if (out_seq !== 16'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_next_seq got seq=%0d v=%b exp 0/1", out_seq, out_valid); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL async_rst got v=%b count=%0d exp 0/0", out_valid, count); end
    step();
    rst = 1'b0;
    trace_en = 1'b1; step(); trace_en = 1'b0;
    n_tests++; if (out_seq !== 16'd0 || count !== 5'd1) begin n_fail++; $display("FAIL post_rst got seq=%0d count=%0d exp 0/1", out_seq, count); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_x0();
    test_overflow();
    test_back_to_back();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_trace_buf.md
Name: core_trace_buf

Overview:
- Consumes the single-cycle core's per-instruction retire signals: PC, instruction word, register-file write enable, write address and write data.
- Packs each retired instruction into a trace record and buffers it in a first-word-fall-through FIFO.
- A host, bench monitor or debug bridge drains records over a valid/ready interface.
- Counts records lost to overflow and tags every record with a sequence number, so the drain side can detect gaps.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 records; legal range 1..8.
- SEQ_W, 16, width of sequence number and drop counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- trace_en  in  1  capture enable; when 1, one record per cycle is offered from the core inputs.
- clear  in  1  synchronous flush of FIFO and counters.
- core_pc  in  32  PC of the retiring instruction.
- core_inst  in  32  instruction word.
- core_rf_we  in  1  register write enable.
- core_rf_waddr  in  5  destination register.
- core_rf_wdata  in  32  register write data (rf din mux output).
- out_valid  out  1  head record available.
- out_ready  in  1  drain side accepts the head record.
- out_seq  out  SEQ_W  sequence number of the head record.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- out_rd_we  out  1  head writeback valid.
- out_rd  out  5  head destination register.
- out_rd_data  out  32  head writeback data.
- count  out  DEPTH_LOG2+1  records currently stored.
- overflow  out  1  sticky flag: at least one record dropped.
- drop_cnt  out  SEQ_W  number of dropped records, saturating.

Behaviour:
- Reset (rst=1, asynchronous): FIFO empty; read and write pointers 0; count=0; out_valid=0; seq counter=0; drop_cnt=0; overflow=0.
  - Payload outputs are don't-care while out_valid=0, but the implementation drives 0 after reset.
- Record format: {seq, pc, inst, rd_we, rd, rd_data}.
  - rd_we is forced to 0 when core_rf_waddr==0, since a write to x0 is not architectural.
  - rd_data is stored unchanged regardless of rd_we.
- Capture attempt: any cycle with trace_en=1 and clear=0.
  - The seq counter is captured into the record, then increments by 1 modulo 2**SEQ_W on every attempt, accepted or dropped, so drops appear as seq gaps.
- Pop: out_valid=1 and out_ready=1 at a rising edge.
  - The read pointer advances; the next record (if any) appears on the outputs in the following cycle.
- Push acceptance: the attempt is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push and pop when full is therefore lossless, and count stays unchanged.
- Drop: an attempt with count == DEPTH and no pop in the same cycle.
  - The record is discarded.
  - overflow is set to 1.
  - drop_cnt increments, saturating at all-ones.
- Count update: count' = count + push_accepted - pop. It never exceeds DEPTH and never underflows; out_ready while empty has no effect.
- Pointers wrap modulo DEPTH; full and empty are distinguished by count only.
- FWFT: out_valid = (count != 0).
  - Outputs reflect the head entry combinationally from storage, with no read latency.
  - A record pushed at edge N is visible at out_* after edge N if the FIFO was empty.
- Handshake rule: while out_valid=1 and out_ready=0, all out_* fields stay stable until popped.
- clear=1 at an edge: empties the FIFO and zeroes seq, drop_cnt and overflow.
  - Any same-cycle push or pop is ignored; clear has priority.
- Reset asserted mid-operation: immediate asynchronous return to the reset state; partially drained contents are lost.
- Storage is a plain register array with no reset on the data array; only pointers, counters and flags are reset.

Test Plan:
- Basic capture: after reset, hold out_ready=0 and pulse trace_en for 3 cycles with pc=0x00,0x04,0x08, inst=0x00500093 (addi x1,x0,5), rf_we=1, waddr=1, wdata=5 → count=3; then raise out_ready → seq 0,1,2 drained in order with pc 0x00,0x04,0x08 and rd=1, rd_data=5; count returns to 0 and out_valid=0.
- x0 filter: capture with waddr=0, rf_we=1, wdata=0x1234 → out_rd_we=0, out_rd=0, out_rd_data=0x1234.
- Overflow: DEPTH=16, out_ready=0, 20 attempts → count=16, overflow=1, drop_cnt=4; drain → seq 0..15; next capture carries seq=20.
- Full with simultaneous push and pop: fill to 16, then hold trace_en=1 and out_ready=1 for 10 cycles → count stays 16, drop_cnt=0, drained seq contiguous.
- Clear and reset priority: with count=5 and overflow=1, assert clear with trace_en=1 and out_ready=1 for one edge → count=0, overflow=0, drop_cnt=0, next capture seq=0; separately, assert rst asynchronously between edges → out_valid drops to 0 immediately, before the next clk edge.
